alu_sequencer: RTL
==================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits.
REQ-002 btnC  in  1  clock; all state updates on rising edge.
REQ-003 btnU  in  1  reset; asynchronous, active-low.
REQ-004 start  in  1  request pulse; sampled only in IDLE.
REQ-005 op  in  4  opcode: 0 ADD, 1 SUB, 2 SHL, 3 SHR, 4 AND, 5 OR, 6 XOR, 7 NAND, 8 NOR, 9 XNOR, A NOT, B NEG, C MUL, D-F illegal.
REQ-006 a, b  in  WIDTH  operands; captured when start is accepted.
REQ-007 dp_a, dp_b  out  WIDTH  operands driven to the shared ALU datapath.
REQ-008 alu_sel  out  4  datapath function select, same encoding as op; never C-F.
REQ-009 alu_y  in  WIDTH  combinational datapath result.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 store  out  1  one-cycle write strobe to the result memory.
REQ-012 result  out  WIDTH  registered result; held until next store.
REQ-013 done  out  1  one-cycle pulse, coincident with store or err.
REQ-014 err  out  1  one-cycle pulse on illegal opcode.

Function
REQ-015 FSM states: IDLE, EXEC, MUL, WRITE.
REQ-016 IDLE + start: latch a, b, op into opa_r, opb_r, op_r; go EXEC for op 0-B, MUL for op C (when enabled), else pulse err and done next cycle and stay IDLE.
REQ-017 EXEC (1 cycle): dp_a=opa_r, dp_b=opb_r, alu_sel=op_r; capture alu_y into acc; go WRITE.
REQ-018 WRITE (1 cycle): result<=acc, store=1, done=1; go IDLE.
REQ-019 Single-cycle op latency: start sampled at edge N, done/store high in the cycle after edge N+2.
REQ-020 MUL: shift-add over the shared datapath, exactly WIDTH cycles; iteration i: if opb_r[i]=1, then dp_a=acc, dp_b=opa_r<<i, alu_sel=ADD, acc<=alu_y; else acc unchanged; acc cleared on entry.
REQ-021 MUL result = low WIDTH bits of a*b; overflow bits discarded; done after edge N+WIDTH+1.
REQ-022 Iteration counter width = clog2(WIDTH); counter wraps to 0 at exit.
REQ-023 start while busy: ignored, no queuing, no err.
REQ-024 In IDLE and WRITE: dp_a, dp_b = 0, alu_sel = 0.
REQ-025 store and done never asserted in the same cycle as err.

Reset
REQ-026 btnU low: FSM->IDLE; acc, opa_r, opb_r, op_r, counter, result = 0; busy, store, done, err = 0; immediate, without waiting for btnC.
REQ-027 Reset mid-operation aborts; no store issued; result reads 0.

Configuration
REQ-028 ALU_SEQ_MUL_EN defined: opcode C runs REQ-020/021, and MUL state and counter are present.
REQ-029 ALU_SEQ_MUL_EN undefined: MUL state and counter not built; opcode C handled as illegal (err+done, no store).

Structure
REQ-030 Shared package alu_pkg: opcode constants, FSM state enum, WIDTH default.
REQ-031 One sub-module: alu_seq_mul_step (combinational partial-product operand select for iteration i); all else inline.

Verification
REQ-032 a=8'h05, b=8'h03, op=0 -> done at N+2, result=8'h08, store pulse 1 cycle.
REQ-033 a=8'h03, b=8'h05, op=1 -> result=8'hFE; second start during busy ignored.
REQ-034 MUL_EN: a=8'h0C, b=8'h0B, op=C -> busy 9 cycles, result=8'h84; a=8'h10, b=8'h10 -> result=8'h00.
REQ-035 op=F -> err and done pulse at N+1, no store, result unchanged.
REQ-036 btnU low during 4th MUL iteration -> all outputs 0 immediately, IDLE, next ADD works normally.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state codes and default operand width
// shared by the alu_sequencer slice.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_SHL  = 4'h2;
  localparam logic [3:0] OP_SHR  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NAND = 4'h7;
  localparam logic [3:0] OP_NOR  = 4'h8;
  localparam logic [3:0] OP_XNOR = 4'h9;
  localparam logic [3:0] OP_NOT  = 4'hA;
  localparam logic [3:0] OP_NEG  = 4'hB;
  localparam logic [3:0] OP_MUL  = 4'hC;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_EXEC  = 2'd1;
  localparam state_t ST_MUL   = 2'd2;
  localparam state_t ST_WRITE = 2'd3;

endpackage

// File: rtl/alu_seq_mul_step.sv
// alu_seq_mul_step: operand select for one shift-add MUL iteration;
// drives acc + (opa << idx) onto the datapath when opb[idx] is set.
module alu_seq_mul_step
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CW    = $clog2(ALU_WIDTH)
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic [CW-1:0]    idx_i,
  output logic [WIDTH-1:0] dp_a_o,
  output logic [WIDTH-1:0] dp_b_o,
  output logic             add_o
);

  assign add_o  = opb_i[idx_i];
  assign dp_a_o = add_o ? acc_i : '0;
  assign dp_b_o = add_o ? (opa_i << idx_i) : '0;

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: sequences ALU ops over a shared external datapath.
// Define ALU_SEQ_MUL_EN to build the shift-add multiply (opcode C).
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             btnC,
  input  logic             btnU,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] dp_a,
  output logic [WIDTH-1:0] dp_b,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_y,
  output logic             busy,
  output logic             store,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             err
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             store_q, store_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

`ifdef ALU_SEQ_MUL_EN
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] step_a, step_b;
  logic             step_add;

  alu_seq_mul_step #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_step (
    .acc_i  (acc_q),
    .opa_i  (opa_q),
    .opb_i  (opb_q),
    .idx_i  (cnt_q),
    .dp_a_o (step_a),
    .dp_b_o (step_b),
    .add_o  (step_add)
  );
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    op_d    = op_q;
    res_d   = res_q;
    store_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    dp_a    = '0;
    dp_b    = '0;
    alu_sel = OP_ADD;
`ifdef ALU_SEQ_MUL_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          opa_d = a;
          opb_d = b;
          op_d  = op;
          unique case (1'b1)
            (op <= OP_NEG): state_d = ST_EXEC;
`ifdef ALU_SEQ_MUL_EN
            (op == OP_MUL): begin
              state_d = ST_MUL;
              acc_d   = '0;
              cnt_d   = '0;
            end
`endif
            default: begin
              err_d  = 1'b1;
              done_d = 1'b1;
            end
          endcase
        end
      end
      ST_EXEC: begin
        dp_a    = opa_q;
        dp_b    = opb_q;
        alu_sel = op_q;
        acc_d   = alu_y;
        state_d = ST_WRITE;
      end
`ifdef ALU_SEQ_MUL_EN
      ST_MUL: begin
        dp_a = step_a;
        dp_b = step_b;
        if (step_add) acc_d = alu_y;
        // counter returns to 0 on exit even for non-power-of-2 widths
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_WRITE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      ST_WRITE: begin
        res_d   = acc_q;
        store_d = 1'b1;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge btnC or negedge btnU) begin
    if (!btnU) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      op_q    <= '0;
      res_q   <= '0;
      store_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      res_q   <= res_d;
      store_q <= store_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

`ifdef ALU_SEQ_MUL_EN
  always_ff @(posedge btnC or negedge btnU) begin
    if (!btnU) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`endif

  assign busy   = (state_q != ST_IDLE);
  assign store  = store_q;
  assign done   = done_q;
  assign err    = err_q;
  assign result = res_q;

endmodule
